// File: rtl/pc_sequencer.sv
// ---------------------------------------------------------------------------
// pc_sequencer
//   Program-counter sequencer with a single branch delay slot.
//   A redirect (branch/jump) seen in SEQ is latched as a pending target and the
//   sequential instruction after it (the delay slot) issues first. The target
//   then issues on the next non-stalled cycle.
//
// Ports
//   clk, reset       : single clock, synchronous active-high reset
//   stall_in         : freeze all state this cycle
//   branch_in        : conditional branch taken
//   jump_in          : unconditional jump (priority over branch_in)
//   jump_reg_in      : with jump_in, target comes from alu_result_in
//   alu_result_in    : register-jump target
//   imm_in           : branch offset (words, signed)
//   jindex_in        : jump index field
//   pc_out           : address of the executing instruction
//   link_addr_out    : pc_out + 8
//   in_slot_out      : current instruction is a delay slot
//   addr_err_out     : sticky misaligned register-jump target
//   instr_count_out  : count of non-stalled cycles since reset
// ---------------------------------------------------------------------------
module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_in,
    input  logic        branch_in,
    input  logic        jump_in,
    input  logic        jump_reg_in,
    input  logic [31:0] alu_result_in,
    input  logic [15:0] imm_in,
    input  logic [25:0] jindex_in,
    output logic [31:0] pc_out,
    output logic [31:0] link_addr_out,
    output logic        in_slot_out,
    output logic        addr_err_out,
    output logic [31:0] instr_count_out
);

    localparam logic [0:0] ST_SEQ  = 1'b0;
    localparam logic [0:0] ST_SLOT = 1'b1;

    logic [0:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] tgt_q, tgt_d;
    logic        addr_err_q, addr_err_d;
    logic [31:0] instr_count_q, instr_count_d;

    logic [31:0] pc_plus4;
    logic [31:0] br_tgt;
    logic [31:0] j_tgt;
    logic [31:0] jr_tgt;
    logic [31:0] redir_tgt;
    logic        redir_req;
    logic        jr_misaligned;

    // Target candidates, all relative to the current pc; sums wrap mod 2^32.
    assign pc_plus4  = pc_q + 32'd4;
    assign br_tgt    = pc_plus4 + {{14{imm_in[15]}}, imm_in, 2'b00};
    assign j_tgt     = {pc_plus4[31:28], jindex_in, 2'b00};
    assign jr_tgt    = {alu_result_in[31:2], 2'b00};

    // jump_in wins over branch_in when both are asserted.
    assign redir_req = branch_in | jump_in;
    always_comb begin
        redir_tgt = br_tgt;
        if (jump_in) begin
            redir_tgt = jump_reg_in ? jr_tgt : j_tgt;
        end
    end

    assign jr_misaligned = jump_in & jump_reg_in & (alu_result_in[1:0] != 2'b00);

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        tgt_d         = tgt_q;
        addr_err_d    = addr_err_q;
        instr_count_d = instr_count_q;
        if (!stall_in) begin
            instr_count_d = instr_count_q + 32'd1;
            case (state_q)
                ST_SEQ: begin
                    // The delay slot always issues next, redirect or not.
                    pc_d = pc_plus4;
                    if (redir_req) begin
                        tgt_d   = redir_tgt;
                        state_d = ST_SLOT;
                        if (jr_misaligned) begin
                            addr_err_d = 1'b1;
                        end
                    end
                end
                ST_SLOT: begin
                    // Redirect inputs are ignored while the slot executes.
                    pc_d    = tgt_q;
                    state_d = ST_SEQ;
                end
                default: begin
                    state_d = ST_SEQ;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_SEQ;
            pc_q          <= RESET_PC;
            tgt_q         <= 32'd0;
            addr_err_q    <= 1'b0;
            instr_count_q <= 32'd0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            tgt_q         <= tgt_d;
            addr_err_q    <= addr_err_d;
            instr_count_q <= instr_count_d;
        end
    end

    assign pc_out          = pc_q;
    assign link_addr_out   = pc_q + 32'd8;
    assign in_slot_out     = (state_q == ST_SLOT);
    assign addr_err_out    = addr_err_q;
    assign instr_count_out = instr_count_q;

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter: RESET_PC, 32'h0040_0000, fetch address loaded on reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 stall_in  input  1  1 = hold all state this cycle (fetch/memory not ready).
REQ-005 branch_in  input  1  conditional branch taken, driven from ALU Branch_out.
REQ-006 jump_in  input  1  unconditional jump, driven from ALU Jump_out.
REQ-007 jump_reg_in  input  1  with jump_in: 1 = JR/JALR (target from alu_result_in), 0 = J/JAL.
REQ-008 alu_result_in  input  32  ALU O_out; register-jump target.
REQ-009 imm_in  input  16  branch offset field of current instruction.
REQ-010 jindex_in  input  26  jump index field of current instruction.
REQ-011 pc_out  output  32  address of instruction executing this cycle.
REQ-012 link_addr_out  output  32  pc_out + 8, return address for JAL/JALR/BxxAL.
REQ-013 in_slot_out  output  1  1 = current instruction is a delay slot.
REQ-014 addr_err_out  output  1  sticky misaligned-target flag.
REQ-015 instr_count_out  output  32  count of executed (non-stalled) cycles.

Function
REQ-016 Two states: SEQ (no redirect pending) and SLOT (redirect pending; current instruction is the delay slot).
REQ-017 Targets computed from current pc_out = P: branch T = P + 4 + (sign-extended imm_in << 2); J T = {(P+4)[31:28], jindex_in, 2'b00}; JR T = alu_result_in with bits [1:0] forced to 00; all sums modulo 2^32, wrap silently.
REQ-018 Redirect request = branch_in | jump_in; jump_in has priority over branch_in when both asserted.
REQ-019 SEQ, stall_in=0, no redirect: pc_out <= P + 4; stay SEQ.
REQ-020 SEQ, stall_in=0, redirect: pc_out <= P + 4; pending target register <= T; go to SLOT.
REQ-021 SLOT, stall_in=0: pc_out <= pending target; go to SEQ; branch_in/jump_in during SLOT ignored (no new redirect captured).
REQ-022 stall_in=1 in either state: pc_out, state, pending target, instr_count_out all hold; redirect inputs ignored that cycle.
REQ-023 in_slot_out = 1 exactly when state is SLOT.
REQ-024 addr_err_out set to 1 when a JR redirect is accepted (SEQ, stall_in=0) with alu_result_in[1:0] != 0; remains 1 until reset.
REQ-025 instr_count_out increments by 1 on every cycle with stall_in=0 and reset=0; wraps 32'hFFFF_FFFF -> 0.
REQ-026 link_addr_out purely combinational from pc_out; zero-latency.
REQ-027 Redirect latency: target appears on pc_out exactly two non-stalled cycles after the branch cycle (one delay slot).

Reset
REQ-028 reset=1 at a rising edge: pc_out <= RESET_PC, state <= SEQ, pending target <= 0, addr_err_out <= 0, instr_count_out <= 0; overrides stall_in and all redirect inputs.
REQ-029 Reset mid-SLOT discards the pending redirect; next fetch is RESET_PC then RESET_PC + 4.

Verification
REQ-030 Reset then 3 free cycles -> pc_out 0x00400000, 0x00400004, 0x00400008, 0x0040000C; instr_count_out 0,1,2,3; link_addr_out 0x00400008 at first cycle.
REQ-031 At pc 0x00400010, branch_in=1, imm_in=16'hFFFC -> next pc 0x00400014 with in_slot_out=1, then pc 0x00400004, in_slot_out=0.
REQ-032 At pc 0x00400020, jump_in=1, jump_reg_in=1, alu_result_in=0x00400103 -> pc 0x00400024, then 0x00400100; addr_err_out=1 and stays 1 until reset.
REQ-033 Branch at 0x00400000 followed by stall_in=1 for 3 cycles in SLOT -> pc_out holds 0x00400004, count holds, then target issued on first unstalled cycle; branch_in asserted during slot has no effect.
REQ-034 J at pc 0xF0000000 with jindex_in=26'h3FFFFFF -> target 0xFFFFFFFC; instr_count preset near 0xFFFFFFFF wraps to 0.
REQ-035 reset asserted while in SLOT with pending target 0x00400100 -> pc_out 0x00400000, in_slot_out=0, pending target never issued.
